uartm_tx_sched: RTL and testbench
=================================

// Module: uartm_tx_sched
// PURPOSE
//  AHB-lite master sequencer and round-robin arbiter for the UART-master TX path.
//  NREQ requesters each post a burst: word-aligned start address plus word count.
//  The block issues one single AHB read per word, then holds off until the TX frame has finished.
//  The read data is captured by the TX shifter (it snoops htrans/hwrite/hready/hrdata).
// PARAMETERS
//  NREQ    2   number of requesters (1..8)
//  LENW    16  width of each burst word-count field
// PORTS
//  hclk        in   1          clock
//  hresetn     in   1          asynchronous, active-low reset
//  req         in   NREQ       level request, one per requester
//  req_addr    in   NREQ*32    start address per requester; bits[1:0] ignored (forced 0)
//  req_len     in   NREQ*LENW  word count per requester
//  grant       out  NREQ       one-hot owner of current burst
//  done        out  NREQ       1-cycle pulse per requester at burst end
//  busy        out  1          high from ARB exit to burst end
//  err         out  1          1-cycle pulse with done when burst aborted on hresp
//  haddr       out  32         AHB address
//  htrans      out  2          AHB trans: IDLE=2'b00 or NONSEQ=2'b10 only
//  hwrite      out  1          tied 0
//  hsize       out  3          tied 3'b010 (word)
//  hready      in   1          AHB ready
//  hresp       in   1          AHB error response
//  uartm_baud  in   32         cycles-per-bit minus 1 (same value the TX uses)
//  uartm_plw   in   8          frame length in bits, incl. start/parity/stop
//  uartm_gap   in   8          idle cycles between frames (UARTM_SCHED_GAP_EN only)
// BEHAVIOUR
//  Reset values: grant=0, done=0, busy=0, err=0, haddr=0, htrans=IDLE.
//  Reset mid-burst: all outputs take reset values asynchronously; the burst is dropped.
//  FSM states:
//   IDLE  -> ARB when |req.
//   ARB   -> 1 cycle; pick the first requester after last_grant, round-robin.
//            latch addr/len and assert grant.
//            len==0 -> DONE without any AHB cycle; otherwise -> ADDR.
//   ADDR  -> drive haddr and htrans=NONSEQ; hold both until hready=1, then -> DATA.
//            htrans returns to IDLE in the cycle after.
//   DATA  -> wait for hready=1.
//            hresp=1 -> DONE with err; otherwise -> FRAME.
//   FRAME -> frame timer runs.
//            bit timer counts 0..uartm_baud; bit counter counts 0..uartm_plw-1.
//            Timer ends after (uartm_baud+1)*uartm_plw + 2 cycles.
//            The +2 covers TX start-bit pipeline slack. No multiplier is used.
//            -> GAP if the macro is defined, otherwise -> NEXT.
//   GAP   -> count uartm_gap cycles; uartm_gap==0 skips the state.
//   NEXT  -> len-1 and addr+4; addr wraps mod 2^32.
//            remaining==0 -> DONE, otherwise -> ADDR.
//   DONE  -> pulse done[owner] (and err if aborted); clear grant and busy.
//            update last_grant; -> IDLE.
//            A new burst starts no earlier than the next cycle.
//  Dropping req mid-burst does not abort the burst; a committed burst always completes.
//  req_addr/req_len are sampled only in ARB; later changes are ignored.
//  A requester with req still high after its own done re-enters arbitration normally.
//  Only one read is ever outstanding; there is no pipelining across frames.
//  uartm_baud/uartm_plw must stay static while busy=1; behaviour otherwise is undefined.
//  Arbitration pointer:
//   last_grant resets to NREQ-1, so requester 0 wins the first tie.
// CONFIGURATION
//  UARTM_SCHED_GAP_EN defined:
//   GAP state and uartm_gap port are present.
//   Inter-frame idle equals the frame time + uartm_gap cycles.
//  UARTM_SCHED_GAP_EN undefined:
//   uartm_gap port is absent; FRAME goes directly to NEXT.
// TESTING
//  1 req[0] with addr 0x100, len 3, baud 3, plw 10, hready=1:
//    NONSEQ reads at 0x100/0x104/0x108, read starts 42 cycles apart; done[0] pulses once, err=0.
//  2 req=2'b11 held, len 1 each:
//    grant order 0,1,0,1...; never two grants in one cycle; done alternates.
//  3 hready=0 for 5 cycles in ADDR:
//    haddr and htrans=NONSEQ held stable; the frame timer starts only after DATA completes.
//  4 hresp=1 on word 2 of a len-4 burst:
//    no further reads; done and err pulse together; next requester then granted.
//  5 len=0:
//    done pulses 2 cycles after req, htrans stays IDLE.
//    Reset asserted mid-FRAME: all outputs go to reset values at once.
//  6 With UARTM_SCHED_GAP_EN and uartm_gap=5:
//    read starts 47 cycles apart (baud 3, plw 10).
//    uartm_gap=0 gives the same 42-cycle spacing as the build without the macro.

Source files
------------

// File: rtl/uartm_tx_sched.sv
// uartm_tx_sched: AHB-lite read sequencer and round-robin arbiter for the
// UART-master TX path. Each granted burst issues one single-word AHB read per
// word and then waits for the TX frame to finish before the next read.
//
// Optional feature macro: UARTM_SCHED_GAP_EN adds the uartm_gap input and a
// GAP state that inserts uartm_gap idle cycles after every frame.
//
// Handshake: an AHB transfer is accepted in the cycle where htrans=NONSEQ and
// hready=1; its data phase completes in the next cycle with hready=1, and
// hresp is sampled only in that cycle. req is a level request; a burst is
// committed in ARB and always runs to its done pulse.
//
// Frame timing: the DATA completion cycle is the first frame-timer cycle, so
// FRAME lasts (baud+1)*plw-1 cycles. Together with the ADDR and NEXT cycles
// the read-to-read spacing is (baud+1)*plw + 2 with zero wait states.
// The bit timer and bit counter avoid any multiplier.

module uartm_tx_sched #(
  parameter int NREQ = 2,
  parameter int LENW = 16
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*LENW-1:0] req_len,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic                 err,
  output logic [31:0]          haddr,
  output logic [1:0]           htrans,
  output logic                 hwrite,
  output logic [2:0]           hsize,
  input  logic                 hready,
  input  logic                 hresp,
  input  logic [31:0]          uartm_baud,
  input  logic [7:0]           uartm_plw,
`ifdef UARTM_SCHED_GAP_EN
  input  logic [7:0]           uartm_gap,
`endif
  output logic [2:0]           dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_FRAME = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [2:0]      state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            abort_q, abort_d;
  logic [31:0]     addr_q, addr_d;
  logic [LENW-1:0] len_q, len_d;
  logic [31:0]     btmr_q, btmr_d;
  logic [7:0]      bcnt_q, bcnt_d;
`ifdef UARTM_SCHED_GAP_EN
  logic [7:0]      gcnt_q, gcnt_d;
`endif

  logic [IW:0]     shamt;
  logic [NREQ-1:0] rot;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  int              pick_tmp;
  logic [31:0]     sel_addr;
  logic [LENW-1:0] sel_len;
  logic            frame_end;

  // Round-robin pick: rotate req so the requester after last_grant is bit 0.
  always_comb begin
    shamt      = {1'b0, last_q} + {{IW{1'b0}}, 1'b1};
    rot        = NREQ'({req, req} >> shamt);
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_tmp   = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && rot[k]) begin
        pick_found = 1'b1;
        pick_tmp   = int'(last_q) + 1 + k;
        if (pick_tmp >= NREQ) pick_tmp = pick_tmp - NREQ;
        pick_idx   = IW'(pick_tmp);
      end
    end
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_addr = req_addr[i*32 +: 32];
        sel_len  = req_len[i*LENW +: LENW];
      end
    end
  end

  // Frame ends on the last bit-timer tick of the last bit.
  always_comb begin
    frame_end = (btmr_q == uartm_baud) &&
                (({1'b0, bcnt_q} + 9'd1) >= {1'b0, uartm_plw});
  end

  // Sequencer next-state and datapath.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    abort_d = abort_q;
    addr_d  = addr_q;
    len_d   = len_q;
    btmr_d  = btmr_q;
    bcnt_d  = bcnt_q;
`ifdef UARTM_SCHED_GAP_EN
    gcnt_d  = gcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) state_d = S_ARB;
      end
      S_ARB: begin
        if (pick_found) begin
          owner_d = pick_idx;
          grant_d = NREQ'(1) << pick_idx;
          busy_d  = 1'b1;
          abort_d = 1'b0;
          addr_d  = {sel_addr[31:2], 2'b00};
          len_d   = sel_len;
          state_d = (sel_len == '0) ? S_DONE : S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (hready) state_d = S_DATA;
      end
      S_DATA: begin
        if (hready) begin
          if (hresp) begin
            abort_d = 1'b1;
            state_d = S_DONE;
          end else begin
            // This cycle already counts as frame-timer cycle 0.
            if (uartm_baud == 32'd0) begin
              btmr_d = 32'd0;
              bcnt_d = 8'd1;
            end else begin
              btmr_d = 32'd1;
              bcnt_d = 8'd0;
            end
            state_d = S_FRAME;
          end
        end
      end
      S_FRAME: begin
        if (btmr_q == uartm_baud) begin
          btmr_d = 32'd0;
          bcnt_d = bcnt_q + 8'd1;
        end else begin
          btmr_d = btmr_q + 32'd1;
        end
        if (frame_end) begin
`ifdef UARTM_SCHED_GAP_EN
          if (uartm_gap != 8'd0) begin
            gcnt_d  = 8'd0;
            state_d = S_GAP;
          end else begin
            state_d = S_NEXT;
          end
`else
          state_d = S_NEXT;
`endif
        end
      end
      S_GAP: begin
`ifdef UARTM_SCHED_GAP_EN
        gcnt_d = gcnt_q + 8'd1;
        if (({1'b0, gcnt_q} + 9'd1) >= {1'b0, uartm_gap}) state_d = S_NEXT;
`else
        state_d = S_NEXT;
`endif
      end
      S_NEXT: begin
        len_d   = len_q - LENW'(1);
        addr_d  = addr_q + 32'd4;
        state_d = (len_q == LENW'(1)) ? S_DONE : S_ADDR;
      end
      S_DONE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        abort_d = 1'b0;
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; asynchronous reset drops any burst in flight.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NREQ - 1);
      owner_q <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      btmr_q  <= '0;
      bcnt_q  <= '0;
`ifdef UARTM_SCHED_GAP_EN
      gcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      abort_q <= abort_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      btmr_q  <= btmr_d;
      bcnt_q  <= bcnt_d;
`ifdef UARTM_SCHED_GAP_EN
      gcnt_q  <= gcnt_d;
`endif
    end
  end

  // Outputs are decoded from registers only.
  always_comb begin
    grant     = grant_q;
    done      = (state_q == S_DONE) ? grant_q : '0;
    err       = (state_q == S_DONE) && abort_q;
    busy      = busy_q;
    haddr     = addr_q;
    htrans    = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    hwrite    = 1'b0;
    hsize     = 3'b010;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_uartm_tx_sched.sv
// Bench for uartm_tx_sched: directed bursts with a scoreboard of expected
// reads ({spacing, address}) and expected done events ({err, done}).
module tb_uartm_tx_sched;
  localparam int NREQ = 2;
  localparam int LENW = 16;

  logic                 hclk;
  logic                 hresetn;
  logic [NREQ-1:0]      req;
  logic [NREQ*32-1:0]   req_addr;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic                 busy;
  logic                 err;
  logic [31:0]          haddr;
  logic [1:0]           htrans;
  logic                 hwrite;
  logic [2:0]           hsize;
  logic                 hready;
  logic                 hresp;
  logic [31:0]          uartm_baud;
  logic [7:0]           uartm_plw;
`ifdef UARTM_SCHED_GAP_EN
  logic [7:0]           uartm_gap;
`endif
  logic [2:0]           dbg_state;

  uartm_tx_sched #(.NREQ(NREQ), .LENW(LENW)) dut (
    .hclk(hclk), .hresetn(hresetn), .req(req), .req_addr(req_addr),
    .req_len(req_len), .grant(grant), .done(done), .busy(busy), .err(err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hready(hready), .hresp(hresp), .uartm_baud(uartm_baud),
    .uartm_plw(uartm_plw),
`ifdef UARTM_SCHED_GAP_EN
    .uartm_gap(uartm_gap),
`endif
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;
  int cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  // Scoreboard state
  logic [63:0]   exp_rd_q[$];
  logic [NREQ:0] exp_done_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for DUT (t=%0t)", name, $time);
  endtask

  task automatic push_rd(input logic [31:0] sp, input logic [31:0] a);
    exp_rd_q.push_back({sp, a});
  endtask

  // Monitor: compares every accepted read and every done pulse.
  logic [1:0]  prev_htrans = 2'b00;
  int          prev_start = 0;
  int          meas_sp = 0;
  logic [63:0] e_rd;
  logic [NREQ:0] e_dn;
  always @(negedge hclk) begin
    if (!hresetn) begin
      prev_htrans = 2'b00;
    end else begin
      if (htrans == 2'b10 && prev_htrans != 2'b10) begin
        meas_sp    = cyc - prev_start;
        prev_start = cyc;
      end
      prev_htrans = htrans;
      if (htrans == 2'b10 && hready) begin
        if (exp_rd_q.size() == 0) begin
          check("unexpected_read", {32'd0, haddr}, 64'hDEAD);
        end else begin
          e_rd = exp_rd_q.pop_front();
          check("read_addr", {32'd0, haddr}, {32'd0, e_rd[31:0]});
          if (e_rd[63:32] != 32'd0) check("read_spacing", 64'(meas_sp), {32'd0, e_rd[63:32]});
        end
      end
      if (done != '0 || err) begin
        if (exp_done_q.size() == 0) begin
          check("unexpected_done", {61'd0, err, done}, 64'hDEAD);
        end else begin
          e_dn = exp_done_q.pop_front();
          check("done_err", {61'd0, err, done}, {61'd0, e_dn});
          check("done_matches_grant", {62'd0, done}, {62'd0, grant});
          check("grant_onehot", {63'd0, $onehot(grant)}, 64'd1);
        end
      end
    end
  end

  // Driver tasks; all input changes happen 1 time unit after a rising edge.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [15:0] l);
    req_addr[i*32 +: 32]   = a;
    req_len[i*LENW +: LENW] = l;
  endtask

  task automatic wait_grant(input int i);
    int n;
    n = 0;
    while (!grant[i] && n < 2000) begin
      tick();
      n++;
    end
    if (!grant[i]) timeout("wait_grant");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    while ((busy || dbg_state != 3'd0) && n < 3000) begin
      tick();
      n++;
    end
    if (busy) timeout("wait_idle");
    repeat (3) tick();
  endtask

  task automatic single_burst(input int i, input logic [31:0] a, input logic [15:0] l);
    set_req(i, a, l);
    req[i] = 1'b1;
    wait_grant(i);
    req[i] = 1'b0;
    wait_idle();
  endtask

  int n_done;
  int n;

  initial begin
    hresetn = 1'b0; req = '0; req_addr = '0; req_len = '0;
    hready = 1'b1; hresp = 1'b0; uartm_baud = 32'd3; uartm_plw = 8'd10;
`ifdef UARTM_SCHED_GAP_EN
    uartm_gap = 8'd0;
`endif
    repeat (3) tick();
    check("rst_grant", {62'd0, grant}, 64'd0);
    check("rst_done", {62'd0, done}, 64'd0);
    check("rst_busy_err", {62'd0, busy, err}, 64'd0);
    check("rst_haddr", {32'd0, haddr}, 64'd0);
    check("rst_htrans", {62'd0, htrans}, 64'd0);
    check("hwrite_hsize", {60'd0, hwrite, hsize}, 64'h2);
    hresetn = 1'b1;
    repeat (2) tick();

    // Round robin from reset: requester 0 wins first, then alternation.
    set_req(0, 32'h200, 16'd1);
    set_req(1, 32'h300, 16'd1);
    push_rd(0, 32'h200); push_rd(0, 32'h300); push_rd(0, 32'h200); push_rd(0, 32'h300);
    exp_done_q.push_back(3'b001); exp_done_q.push_back(3'b010);
    exp_done_q.push_back(3'b001); exp_done_q.push_back(3'b010);
    req = 2'b11;
    n_done = 0; n = 0;
    while (n_done < 4 && n < 3000) begin
      tick();
      if (done != '0) n_done++;
      n++;
    end
    if (n_done < 4) timeout("rr_dones");
    req = '0;
    wait_idle();

    // Three-word burst, zero wait states: reads 42 cycles apart.
    push_rd(0, 32'h100); push_rd(42, 32'h104); push_rd(42, 32'h108);
    exp_done_q.push_back(3'b001);
    single_burst(0, 32'h100, 16'd3);

    // Address stalled for 5 cycles; low address bits are ignored.
    hready = 1'b0;
    push_rd(0, 32'h400); push_rd(47, 32'h404);
    exp_done_q.push_back(3'b001);
    set_req(0, 32'h403, 16'd2);
    req[0] = 1'b1;
    n = 0;
    while (htrans != 2'b10 && n < 200) begin
      tick();
      n++;
    end
    if (htrans != 2'b10) timeout("stall_addr");
    req[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) tick();
      check("stall_haddr", {32'd0, haddr}, 64'h400);
      check("stall_htrans", {62'd0, htrans}, 64'h2);
    end
    tick();
    hready = 1'b1;
    wait_idle();

    // Error on word 2 of a 4-word burst; requester 0 served afterwards.
    set_req(1, 32'h500, 16'd4);
    set_req(0, 32'h600, 16'd1);
    push_rd(0, 32'h500); push_rd(42, 32'h504); push_rd(0, 32'h600);
    exp_done_q.push_back(3'b110); exp_done_q.push_back(3'b001);
    req = 2'b11;
    wait_grant(1);
    req[1] = 1'b0;
    n = 0;
    while (!(htrans == 2'b10 && haddr == 32'h504) && n < 300) begin
      tick();
      n++;
    end
    if (haddr != 32'h504) timeout("err_word2");
    tick();
    hresp = 1'b1;
    tick();
    hresp = 1'b0;
    wait_grant(0);
    req[0] = 1'b0;
    wait_idle();

    // Zero-length burst: done two cycles after req, no bus cycle.
    set_req(0, 32'h800, 16'd0);
    exp_done_q.push_back(3'b001);
    req[0] = 1'b1;
    tick();
    check("len0_no_early_done", {62'd0, done}, 64'd0);
    tick();
    check("len0_done", {62'd0, done}, 64'd1);
    check("len0_htrans", {62'd0, htrans}, 64'd0);
    req[0] = 1'b0;
    wait_idle();

    // Reset in the middle of a frame.
    push_rd(0, 32'h900);
    set_req(0, 32'h900, 16'd2);
    req[0] = 1'b1;
    wait_grant(0);
    req[0] = 1'b0;
    repeat (10) tick();
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    hresetn = 1'b0;
    #1;
    check("midrst_grant", {62'd0, grant}, 64'd0);
    check("midrst_busy_err", {62'd0, busy, err}, 64'd0);
    check("midrst_haddr", {32'd0, haddr}, 64'd0);
    check("midrst_htrans_done", {60'd0, htrans, done}, 64'd0);
    repeat (2) tick();
    hresetn = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", {61'd0, busy, htrans}, 64'd0);

    // Address wraps modulo 2^32.
    push_rd(0, 32'hFFFF_FFFC); push_rd(42, 32'h0000_0000);
    exp_done_q.push_back(3'b010);
    single_burst(1, 32'hFFFF_FFFC, 16'd2);

`ifdef UARTM_SCHED_GAP_EN
    uartm_gap = 8'd5;
    push_rd(0, 32'hA00); push_rd(47, 32'hA04);
    exp_done_q.push_back(3'b001);
    single_burst(0, 32'hA00, 16'd2);
    uartm_gap = 8'd0;
    push_rd(0, 32'hB00); push_rd(42, 32'hB04);
    exp_done_q.push_back(3'b001);
    single_burst(0, 32'hB00, 16'd2);
`endif

    repeat (5) tick();
    check("reads_left", 64'(exp_rd_q.size()), 64'd0);
    check("dones_left", 64'(exp_done_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
